// File: rtl/sb_pkg.sv
// Shared types for the dual-issue interlock scoreboard.
package sb_pkg;
  localparam int SB_NREG = 32;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MUL  = 2'd2,
    LAT_DIV  = 2'd3
  } lat_class_e;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;
endpackage

// File: rtl/sb_slot_chk.sv
// Per-slot hazard check: RAW on either read-enabled source, WAW on the
// destination, and structural block on the divider.
module sb_slot_chk
  import sb_pkg::*;
(
  input  logic [4:0]         i_raddr1,
  input  logic [4:0]         i_raddr2,
  input  logic [1:0]         i_re,
  input  logic [4:0]         i_waddr,
  input  logic               i_we,
  input  logic [1:0]         i_lat,
  input  logic [SB_NREG-1:0] i_eff_pend,
  input  logic               i_div_busy,
  output logic               o_block
);
  logic w_raw, w_waw, w_div;

  // r0 never appears in i_eff_pend, so r0 operands never block here
  assign w_raw   = (i_re[0] && i_eff_pend[i_raddr1]) ||
                   (i_re[1] && i_eff_pend[i_raddr2]);
  assign w_waw   = i_we && i_eff_pend[i_waddr];
  assign w_div   = (i_lat == LAT_DIV) && i_div_busy;
  assign o_block = w_raw || w_waw || w_div;
endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue ID->EX interlock. Tracks registers whose LOAD/MUL/DIV results
// are only visible from WB, decides slot A / slot B issue each cycle and
// serialises the multi-cycle divider.
// Optional: define SB_STALL_CNT_EN to build the saturating ID stall counter;
// otherwise stall_cnt is tied to zero.
module issue_scoreboard
  import sb_pkg::*;
#(
  parameter int DIV_LAT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ID_valid_a,
  input  logic        ID_valid_b,
  input  logic [4:0]  ID_rf_raddr_a1,
  input  logic [4:0]  ID_rf_raddr_a2,
  input  logic [4:0]  ID_rf_raddr_b1,
  input  logic [4:0]  ID_rf_raddr_b2,
  input  logic [1:0]  ID_rf_re_a,
  input  logic [1:0]  ID_rf_re_b,
  input  logic [4:0]  ID_rf_waddr_a,
  input  logic [4:0]  ID_rf_waddr_b,
  input  logic        ID_rf_we_a,
  input  logic        ID_rf_we_b,
  input  logic [1:0]  ID_lat_a,
  input  logic [1:0]  ID_lat_b,
  input  logic        EX_ready,
  input  logic [4:0]  WB_rf_waddr_a,
  input  logic [4:0]  WB_rf_waddr_b,
  input  logic        WB_rf_we_a,
  input  logic        WB_rf_we_b,
  input  logic        flush_all,
  output logic        issue_a,
  output logic        issue_b,
  output logic        div_busy,
  output logic [31:0] stall_cnt
);
  localparam int CW = $clog2(DIV_LAT + 1);

  logic [SB_NREG-1:0] r_pend;
  logic [CW-1:0]      r_div_cnt;
  div_state_e         r_div_state;

  logic [SB_NREG-1:0] w_clr, w_set_a, w_set_b, w_eff;
  logic               w_div_nz, w_blk_a, w_blk_b_base, w_pair_blk;
  logic               w_a_dst, w_div_issue;

  // WB writes this cycle unblock readers immediately (write-through RF)
  assign w_clr = (WB_rf_we_a ? (SB_NREG'(1) << WB_rf_waddr_a) : '0) |
                 (WB_rf_we_b ? (SB_NREG'(1) << WB_rf_waddr_b) : '0);
  assign w_eff    = r_pend & ~w_clr;
  assign w_div_nz = (r_div_cnt != '0);

  sb_slot_chk u_chk_a (
    .i_raddr1   (ID_rf_raddr_a1),
    .i_raddr2   (ID_rf_raddr_a2),
    .i_re       (ID_rf_re_a),
    .i_waddr    (ID_rf_waddr_a),
    .i_we       (ID_rf_we_a),
    .i_lat      (ID_lat_a),
    .i_eff_pend (w_eff),
    .i_div_busy (w_div_nz),
    .o_block    (w_blk_a)
  );

  sb_slot_chk u_chk_b (
    .i_raddr1   (ID_rf_raddr_b1),
    .i_raddr2   (ID_rf_raddr_b2),
    .i_re       (ID_rf_re_b),
    .i_waddr    (ID_rf_waddr_b),
    .i_we       (ID_rf_we_b),
    .i_lat      (ID_lat_b),
    .i_eff_pend (w_eff),
    .i_div_busy (w_div_nz),
    .o_block    (w_blk_b_base)
  );

  // Intra-pair hazards: B cannot see A's result in the same issue group.
  // A write to r0 is not a real destination, so it never blocks B.
  assign w_a_dst    = ID_rf_we_a && (ID_rf_waddr_a != 5'd0);
  assign w_pair_blk = (w_a_dst && ID_rf_re_b[0] && (ID_rf_raddr_b1 == ID_rf_waddr_a)) ||
                      (w_a_dst && ID_rf_re_b[1] && (ID_rf_raddr_b2 == ID_rf_waddr_a)) ||
                      (w_a_dst && ID_rf_we_b && (ID_rf_waddr_b == ID_rf_waddr_a)) ||
                      ((ID_lat_a == LAT_LOAD) && (ID_lat_b == LAT_LOAD)) ||
                      ((ID_lat_a == LAT_DIV)  && (ID_lat_b == LAT_DIV));

  assign issue_a = ID_valid_a && EX_ready && !w_blk_a && rstn && !flush_all;
  assign issue_b = issue_a && ID_valid_b && !w_blk_b_base && !w_pair_blk;

  assign w_set_a = (issue_a && ID_rf_we_a && (ID_lat_a != LAT_ALU))
                   ? (SB_NREG'(1) << ID_rf_waddr_a) : '0;
  assign w_set_b = (issue_b && ID_rf_we_b && (ID_lat_b != LAT_ALU))
                   ? (SB_NREG'(1) << ID_rf_waddr_b) : '0;
  assign w_div_issue = (issue_a && (ID_lat_a == LAT_DIV)) ||
                       (issue_b && (ID_lat_b == LAT_DIV));

  // Pending set: flush wins, then set beats same-cycle clear; r0 stays clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          r_pend <= '0;
    else if (flush_all) r_pend <= '0;
    else                r_pend <= ((r_pend & ~w_clr) | w_set_a | w_set_b) & ~SB_NREG'(1);
  end

  // Divider FSM: BUSY exactly while the countdown is non-zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div_cnt   <= '0;
      r_div_state <= DIV_IDLE;
    end else if (flush_all) begin
      r_div_cnt   <= '0;
      r_div_state <= DIV_IDLE;
    end else begin
      case (r_div_state)
        DIV_IDLE: begin
          if (w_div_issue) begin
            r_div_cnt   <= CW'(DIV_LAT);
            r_div_state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (r_div_cnt == CW'(1)) begin
            r_div_cnt   <= '0;
            r_div_state <= DIV_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt - CW'(1);
          end
        end
        default: begin
          r_div_cnt   <= '0;
          r_div_state <= DIV_IDLE;
        end
      endcase
    end
  end

  assign div_busy = (r_div_state == DIV_BUSY);

`ifdef SB_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles where slot A holds an instruction but stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_stall_cnt <= '0;
    else if (ID_valid_a && !issue_a && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: reset, table of pair vectors,
// hand-written multi-cycle sequences and a randomized run against a
// behavioural model of the interlock rules.
module tb_issue_scoreboard;
  localparam int DIV_LAT = 16;

  typedef struct {
    bit       v;
    bit [4:0] r1;
    bit [4:0] r2;
    bit [1:0] re;
    bit [4:0] wd;
    bit       we;
    bit [1:0] lat;
  } ins_t;

  typedef struct {
    string name;
    ins_t  a;
    ins_t  b;
    bit    exr;
    bit    exp_a;
    bit    exp_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  ins_t        ia, ib;
  logic        exr = 1'b1;
  logic [4:0]  wba = '0, wbb = '0;
  logic        wbwa = 1'b0, wbwb = 1'b0;
  logic        flush = 1'b0;
  logic        issue_a, issue_b, div_busy;
  logic [31:0] stall_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // behavioural model state
  bit          m_pend[32];
  int          m_div;
  logic [31:0] m_stall;
  bit          g_act_a, g_act_b;

  issue_scoreboard #(.DIV_LAT(DIV_LAT)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .ID_valid_a     (ia.v),
    .ID_valid_b     (ib.v),
    .ID_rf_raddr_a1 (ia.r1),
    .ID_rf_raddr_a2 (ia.r2),
    .ID_rf_raddr_b1 (ib.r1),
    .ID_rf_raddr_b2 (ib.r2),
    .ID_rf_re_a     (ia.re),
    .ID_rf_re_b     (ib.re),
    .ID_rf_waddr_a  (ia.wd),
    .ID_rf_waddr_b  (ib.wd),
    .ID_rf_we_a     (ia.we),
    .ID_rf_we_b     (ib.we),
    .ID_lat_a       (ia.lat),
    .ID_lat_b       (ib.lat),
    .EX_ready       (exr),
    .WB_rf_waddr_a  (wba),
    .WB_rf_waddr_b  (wbb),
    .WB_rf_we_a     (wbwa),
    .WB_rf_we_b     (wbwb),
    .flush_all      (flush),
    .issue_a        (issue_a),
    .issue_b        (issue_b),
    .div_busy       (div_busy),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic ins_t mk(bit [4:0] wd, bit we, bit [1:0] lat,
                              bit [4:0] r1, bit [4:0] r2, bit [1:0] re);
    ins_t s;
    s.v = 1'b1; s.wd = wd; s.we = we; s.lat = lat;
    s.r1 = r1;  s.r2 = r2; s.re = re;
    return s;
  endfunction

  function automatic ins_t nop();
    ins_t s;
    s.v = 1'b0; s.wd = '0; s.we = 1'b0; s.lat = 2'd0;
    s.r1 = '0;  s.r2 = '0; s.re = 2'b00;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // register r is outstanding and not being written back this cycle
  function automatic bit eff(bit [4:0] r);
    if (r == 0) return 1'b0;
    if (wbwa && wba == r) return 1'b0;
    if (wbwb && wbb == r) return 1'b0;
    return m_pend[r];
  endfunction

  function automatic bit blocked(ins_t s);
    return (s.re[0] && eff(s.r1)) || (s.re[1] && eff(s.r2)) ||
           (s.we && eff(s.wd)) || (s.lat == 2'd3 && m_div > 0);
  endfunction

  task automatic model_eval(output bit ea, output bit eb);
    bit dep;
    ea  = rstn && !flush && ia.v && exr && !blocked(ia);
    dep = ia.we && ia.wd != 0 &&
          ((ib.re[0] && ib.r1 == ia.wd) || (ib.re[1] && ib.r2 == ia.wd) ||
           (ib.we && ib.wd == ia.wd));
    eb  = ea && ib.v && !blocked(ib) && !dep &&
          !(ia.lat == 2'd1 && ib.lat == 2'd1) && !(ia.lat == 2'd3 && ib.lat == 2'd3);
  endtask

  task automatic model_update(input bit ea, input bit eb);
`ifdef SB_STALL_CNT_EN
    if (ia.v && !ea && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
    if (flush) begin
      foreach (m_pend[r]) m_pend[r] = 1'b0;
      m_div = 0;
      return;
    end
    if (wbwa) m_pend[wba] = 1'b0;
    if (wbwb) m_pend[wbb] = 1'b0;
    if (ea && ia.we && ia.wd != 0 && ia.lat != 2'd0) m_pend[ia.wd] = 1'b1;
    if (eb && ib.we && ib.wd != 0 && ib.lat != 2'd0) m_pend[ib.wd] = 1'b1;
    if ((ea && ia.lat == 2'd3) || (eb && ib.lat == 2'd3)) m_div = DIV_LAT;
    else if (m_div > 0) m_div--;
  endtask

  task automatic model_reset();
    foreach (m_pend[r]) m_pend[r] = 1'b0;
    m_div = 0;
    m_stall = '0;
  endtask

  // inputs were set just after a rising edge; sample mid-cycle, then advance
  task automatic step();
    bit ea, eb;
    #3;
    model_eval(ea, eb);
    g_act_a = issue_a;
    g_act_b = issue_b;
    chk("issue_a", {31'd0, issue_a}, {31'd0, ea});
    chk("issue_b", {31'd0, issue_b}, {31'd0, eb});
    chk("div_busy", {31'd0, div_busy}, {31'd0, m_div > 0});
    chk("stall_cnt", stall_cnt, m_stall);
    @(posedge clk);
    model_update(ea, eb);
    #1;
  endtask

  task automatic idle_wb();
    wbwa = 1'b0; wbwb = 1'b0; wba = '0; wbb = '0;
  endtask

  task automatic do_flush();
    ia = nop(); ib = nop(); idle_wb(); flush = 1'b1; exr = 1'b1;
    step();
    flush = 1'b0;
  endtask

  vec_t tbl[10];

  initial begin
    model_reset();
    ia = mk(5'd3, 1'b1, 2'd0, 5'd1, 5'd2, 2'b11);
    ib = nop();
    idle_wb();

    // reset: nothing issues even with a valid slot A
    #2;
    chk("rst_issue_a", {31'd0, issue_a}, 32'd0);
    chk("rst_div_busy", {31'd0, div_busy}, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // single-cycle pair vectors from a clean scoreboard
    tbl[0] = '{"raw_pair",  mk(3,1,0,1,2,2'b11), mk(4,1,0,3,1,2'b11), 1, 1, 0};
    tbl[1] = '{"indep",     mk(3,1,0,1,2,2'b11), mk(4,1,0,5,6,2'b11), 1, 1, 1};
    tbl[2] = '{"two_load",  mk(3,1,1,1,0,2'b01), mk(4,1,1,2,0,2'b01), 1, 1, 0};
    tbl[3] = '{"two_div",   mk(3,1,3,1,2,2'b11), mk(4,1,3,5,6,2'b11), 1, 1, 0};
    tbl[4] = '{"waw_pair",  mk(3,1,0,1,2,2'b11), mk(3,1,2,5,0,2'b01), 1, 1, 0};
    tbl[5] = '{"r0_pair",   mk(0,1,1,1,2,2'b11), mk(4,1,0,0,0,2'b11), 1, 1, 1};
    tbl[6] = '{"ex_busy",   mk(3,1,0,1,2,2'b11), mk(4,1,0,5,6,2'b11), 0, 0, 0};
    tbl[7] = '{"no_valid",  nop(),               nop(),               1, 0, 0};
    tbl[8] = '{"re_off",    mk(3,1,1,1,2,2'b11), mk(4,1,0,3,3,2'b00), 1, 1, 1};
    tbl[9] = '{"load_mul",  mk(3,1,1,1,0,2'b01), mk(4,1,2,5,6,2'b11), 1, 1, 1};
    for (int i = 0; i < 10; i++) begin
      ia = tbl[i].a; ib = tbl[i].b; exr = tbl[i].exr;
      step();
      chk({tbl[i].name, "_a"}, {31'd0, g_act_a}, {31'd0, tbl[i].exp_a});
      chk({tbl[i].name, "_b"}, {31'd0, g_act_b}, {31'd0, tbl[i].exp_b});
      do_flush();
    end

    // LOAD r5 then dependent ADD r6,r5,r1 stalls until WB of r5
    ia = mk(5, 1, 1, 2, 0, 2'b01); ib = nop();
    step();
    chk("ld_issue", {31'd0, g_act_a}, 32'd1);
    ia = mk(6, 1, 0, 5, 1, 2'b11);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("use_stall", {31'd0, g_act_a}, 32'd0);
    end
    wbb = 5'd5; wbwb = 1'b1;
    step();
    chk("wb_bypass", {31'd0, g_act_a}, 32'd1);
    do_flush();

    // dependent pair splits, B moves into A next cycle
    ia = mk(3, 1, 0, 1, 2, 2'b11); ib = mk(4, 1, 0, 3, 1, 2'b11);
    step();
    chk("split_a", {31'd0, g_act_a}, 32'd1);
    chk("split_b", {31'd0, g_act_b}, 32'd0);
    ia = ib; ib = nop();
    step();
    chk("shift_a", {31'd0, g_act_a}, 32'd1);
    do_flush();

    // divider: busy for DIV_LAT cycles, second DIV waits until then
    ia = mk(8, 1, 3, 1, 2, 2'b11);
    step();
    chk("div1_issue", {31'd0, g_act_a}, 32'd1);
    ia = mk(9, 1, 3, 1, 0, 2'b01);
    for (int k = 1; k <= DIV_LAT; k++) begin
      #3;
      chk("div_busy_on", {31'd0, div_busy}, 32'd1);
      #0 step_back();
    end
    #3;
    chk("div_busy_off", {31'd0, div_busy}, 32'd0);
    #0 step_back();
    chk("div2_issue", {31'd0, g_act_a}, 32'd1);
    do_flush();

    // flush clears a pending LOAD and a running divide
    ia = mk(7, 1, 1, 1, 0, 2'b01); ib = mk(9, 1, 3, 1, 2, 2'b11);
    step();
    chk("pre_flush_a", {31'd0, g_act_a}, 32'd1);
    chk("pre_flush_b", {31'd0, g_act_b}, 32'd1);
    ia = mk(1, 1, 0, 7, 2, 2'b11); ib = mk(10, 1, 3, 2, 0, 2'b01);
    flush = 1'b1;
    step();
    chk("flush_supp", {31'd0, g_act_a}, 32'd0);
    flush = 1'b0;
    step();
    chk("post_flush_a", {31'd0, g_act_a}, 32'd1);
    chk("post_flush_b", {31'd0, g_act_b}, 32'd1);
    do_flush();

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      ia = mk($urandom_range(0, 7), 1'($urandom), 2'($urandom),
              $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom));
      ia.v = ($urandom_range(0, 7) != 0);
      ib = mk($urandom_range(0, 7), 1'($urandom), 2'($urandom),
              $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom));
      ib.v = ia.v && 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin ia.lat[1] = ia.lat[0] & ia.lat[1]; end
      exr   = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 39) == 0);
      wba = $urandom_range(0, 7); wbb = $urandom_range(0, 7);
      wbwa = 1'($urandom); wbwb = 1'($urandom);
      step();
    end
    idle_wb();
    flush = 1'b0;
    exr = 1'b1;

    // reset mid-divide abandons the count at once
    do_flush();
    ia = mk(9, 1, 3, 1, 2, 2'b11); ib = nop();
    step();
    ia = nop();
    for (int k = 0; k < 7; k++) step();
    ia = mk(9, 1, 3, 1, 2, 2'b11);
    rstn = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, div_busy}, 32'd0);
    chk("rst_mid_issue", {31'd0, issue_a}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    ia = mk(3, 1, 0, 1, 2, 2'b11);
    exr = 1'b0;
    for (int k = 0; k < 3; k++) step();
    exr = 1'b1;
    ia = nop();
    #3;
`ifdef SB_STALL_CNT_EN
    chk("stall_3", stall_cnt, 32'd3);
`else
    chk("stall_tied", stall_cnt, 32'd0);
`endif
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // step() for callers that already waited the 3 ns sampling offset
  task automatic step_back();
    #(-0);
    begin
      bit ea, eb;
      model_eval(ea, eb);
      g_act_a = issue_a;
      g_act_b = issue_b;
      chk("issue_a", {31'd0, issue_a}, {31'd0, ea});
      chk("issue_b", {31'd0, issue_b}, {31'd0, eb});
      chk("stall_cnt", stall_cnt, m_stall);
      @(posedge clk);
      model_update(ea, eb);
      #1;
    end
  endtask
endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Dual-issue interlock controller between ID and EX. It tracks registers whose results cannot be forwarded by the EX-stage forwarding network: loads, multiplies and divides are visible only from WB. It decides each cycle whether slot A, then slot B, of the decoded pair may enter EX. It also serialises the multi-cycle divider.

## Interface
Parameters:
- DIV_LAT, 16: cycles the divider stays busy after a DIV issues; legal range ≥2.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- ID_valid_a / ID_valid_b  in  1  slot holds a valid instruction; B valid implies A valid.
- ID_rf_raddr_a1/a2/b1/b2  in  5  source register addresses.
- ID_rf_re_a / ID_rf_re_b  in  2  per-source read enables; bit0 = src1, bit1 = src2.
- ID_rf_waddr_a / ID_rf_waddr_b  in  5  destination register.
- ID_rf_we_a / ID_rf_we_b  in  1  destination write enable.
- ID_lat_a / ID_lat_b  in  2  result class: ALU, LOAD, MUL or DIV.
- EX_ready  in  1  EX can accept an issue this cycle.
- WB_rf_waddr_a / WB_rf_waddr_b  in  5  WB write address.
- WB_rf_we_a / WB_rf_we_b  in  1  WB write enable.
- flush_all  in  1  full pipeline kill (exception or ertn); all in-flight results are discarded.
- issue_a / issue_b  out  1  slot enters EX at this edge.
- div_busy  out  1  divider counter is non-zero.
- stall_cnt  out  32  ID stall-cycle count (see Configuration).

## Operation
- State: `pend[31:1]` holds 1 bit per register, meaning a non-ALU result is outstanding. `div_cnt` is a counter ⌈log2(DIV_LAT+1)⌉ bits wide. Register r0 is never pending; r0 reads never stall.
- WB clear for this cycle: `clr[r]` is set when `WB_rf_we_x && WB_rf_waddr_x==r`, for either x. A register is treated as effectively pending when `pend[r] && !clr[r]`. WB bypass relies on the register file being write-through.
- Slot A blocks on any of:
  - a read-enabled source that is effectively pending;
  - `ID_rf_we_a` with an effectively pending destination (WAW);
  - `ID_lat_a==DIV` while `div_cnt!=0`.
- Slot B blocks on any slot-A rule applied to B, or on any of:
  - A is not issuing;
  - B reads A's destination while `ID_rf_we_a` is set;
  - B writes A's destination;
  - both slots are LOAD;
  - both slots are DIV.
- Issue logic:
  - `issue_a = ID_valid_a && EX_ready && !blockA && rstn && !flush_all`.
  - `issue_b = issue_a && ID_valid_b && !blockB`.
  - A lone A issue means B stays in ID; ID shifts it into slot A.
- Set: on an issued slot with `we`, `waddr!=0` and class ≠ ALU, `pend[waddr]` is set at the edge. Set beats a same-cycle clear of the same register.
- DIV: an issued DIV loads `div_cnt=DIV_LAT`. Otherwise `div_cnt` decrements while non-zero, independent of `EX_ready`.
- Divider FSM: IDLE when `div_cnt==0`, BUSY otherwise. IDLE→BUSY on DIV issue. BUSY→IDLE when the count reaches 0.
- flush_all: clears all of `pend` and `div_cnt` at the edge and suppresses issue in the same cycle. It has priority over set and clear.

## Timing
- Issue decision is combinational from registered state plus ID and WB inputs; zero-cycle latency.
- A register set at edge N blocks readers from cycle N+1. A WB write in cycle M unblocks readers in cycle M itself.
- A DIV issued at edge N blocks a second DIV for cycles N+1 … N+DIV_LAT. A new DIV can issue in cycle N+DIV_LAT+1.
- Reset (asynchronous assert, synchronous-safe release):
  - `pend=0`, `div_cnt=0`, `div_busy=0`, `stall_cnt=0`;
  - `issue_a=issue_b=0` while `rstn` is low.
- Reset mid-divide abandons the count immediately.

## Configuration
- `SB_STALL_CNT_EN` defined: `stall_cnt` increments by 1 each cycle `ID_valid_a && !issue_a`. It saturates at 0xFFFFFFFF and clears on reset only.
- `SB_STALL_CNT_EN` undefined: the counter is not built and `stall_cnt` is tied to 0.

## Structure
- Package `sb_pkg` contains:
  - enum `lat_class_e` {LAT_ALU=0, LAT_LOAD=1, LAT_MUL=2, LAT_DIV=3};
  - localparam `SB_NREG=32`.
- Sub-module `sb_slot_chk`, instantiated twice: it takes one slot's sources, destination, class and the effective-pending vector, and returns that slot's base block condition. The top level adds the intra-pair rules, FSM, `pend` and counters.

## Test plan
- LOAD r5 issues in A at cycle 0; at cycle 1, ADD r6,r5,r1 in A → `issue_a=0` through WB. In the WB cycle with `WB_rf_waddr_b=5`, `WB_rf_we_b=1` → `issue_a=1` in that same cycle.
- Pair A=ADD r3,r1,r2, B=SUB r4,r3,r1 with `EX_ready=1` → `issue_a=1`, `issue_b=0`. Next cycle B presented as A → issues.
- DIV issue with DIV_LAT=16 → `div_busy=1` for 16 cycles. A second DIV → stalled until cycle 17, then issues.
- LOAD r7 pending and `flush_all=1` → next cycle `pend=0`, `div_cnt=0`, and a reader of r7 issues immediately.
- Pair with both slots LOAD, no dependences → `issue_a=1`, `issue_b=0`. Reads or writes of r0 never block.
- `rstn` low mid-divide (`div_cnt=9`) → `div_busy=0` asynchronously. With `SB_STALL_CNT_EN`, `stall_cnt` reads 0 after release and counts 3 after 3 blocked cycles.
